// File: rtl/mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_pkg
//   Shared bus definitions for the memory-bus arbiter: data/address/select
//   widths, byte/word select constants and the arbiter FSM state encoding.
//   No ports; imported by mem_bus_arbiter and mem_lane_extract.
// ---------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int SEL_W  = 4;

  localparam logic [SEL_W-1:0]  SEL_BYTE       = 4'b0001;
  localparam logic [SEL_W-1:0]  SEL_WORD       = 4'b1111;
  localparam logic [ADDR_W-1:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane_extract.sv
// ---------------------------------------------------------------------------
// mem_lane_extract
//   Combinational load-data formatter. For a byte access it picks the byte
//   lane addressed by lane and sign- or zero-extends it to 32 bits; for a
//   word access the read data passes through unchanged.
// Ports:
//   rdata    in  [31:0]  raw bus read data
//   lane     in  [1:0]   byte lane (low address bits of the access)
//   byte_acc in          1 = byte access, 0 = word access
//   sign_ext in          1 = sign-extend the byte, 0 = zero-extend
//   data     out [31:0]  formatted load data
// ---------------------------------------------------------------------------
module mem_lane_extract
  import mem_bus_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        lane,
  input  logic              byte_acc,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] data
);

  logic [7:0] lane_byte;

  always_comb begin
    lane_byte = rdata[7:0];
    case (lane)
      2'd1:    lane_byte = rdata[15:8];
      2'd2:    lane_byte = rdata[23:16];
      2'd3:    lane_byte = rdata[31:24];
      default: lane_byte = rdata[7:0];
    endcase

    if (!byte_acc)
      data = rdata;
    else if (sign_ext)
      data = {{24{lane_byte[7]}}, lane_byte};
    else
      data = {24'd0, lane_byte};
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Arbitrates one shared memory bus between the ID/EX data path (loads and
//   stores) and instruction fetch. Data accesses win over fetch when both are
//   pending. Bus request fields are registered when leaving IDLE and held
//   until bus_ack; results come back as single-cycle valid pulses the cycle
//   after the ack. stall_req freezes the pipeline while any presented request
//   has not yet delivered its valid pulse.
//
// Optional feature (macro MEM_ALIGN_CHECK_EN): misaligned word accesses issue
//   no bus cycle and instead pulse addr_err together with load_valid
//   (load_data = 0). Without the macro, misaligned words are issued with
//   address bits [1:0] cleared and there is no addr_err port.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   mem_read_flag/mem_write_flag data load / store request
//   mem_sign_ext_flag            sign-extend byte loads
//   mem_sel [3:0]                0001 = byte access, 1111 = word access
//   mem_addr, mem_write_data     data access address / store data
//   if_req, if_addr              instruction fetch request / address
//   bus_req, bus_we, bus_sel,
//   bus_addr, bus_wdata          registered shared-bus request
//   bus_ack, bus_rdata           bus completion / read data
//   inst_valid, inst_data        fetch result pulse / data
//   load_valid, load_data        load result (or store completion) pulse
//   stall_req                    pipeline freeze (combinational)
//   addr_err                     misaligned word access (MEM_ALIGN_CHECK_EN)
// ---------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_flag,
  input  logic              mem_write_flag,
  input  logic              mem_sign_ext_flag,
  input  logic [SEL_W-1:0]  mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_write_data,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              bus_req,
  output logic              bus_we,
  output logic [SEL_W-1:0]  bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic              load_valid,
  output logic [DATA_W-1:0] load_data,
  output logic              stall_req
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              addr_err
`endif
);

  state_t            state;
  logic              done_data;
  logic              done_inst;
  logic [1:0]        lane_r;
  logic              byte_r;
  logic              sext_r;
  logic [DATA_W-1:0] ext_data;

  logic data_req;
  logic data_go;
  logic inst_go;
  logic is_byte;
  logic misaligned;

  // done_* remember a request that already delivered its valid pulse while
  // the pipeline is still frozen by the other requester, so it is not
  // re-issued before the pipeline advances.
  assign data_req  = mem_read_flag | mem_write_flag;
  assign data_go   = data_req & ~done_data & ~load_valid;
  assign inst_go   = if_req & ~done_inst & ~inst_valid;
  assign stall_req = ~rst & (data_go | inst_go);
  assign is_byte   = (mem_sel == SEL_BYTE);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ~is_byte & (mem_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  mem_lane_extract u_lane_extract (
    .rdata    (bus_rdata),
    .lane     (lane_r),
    .byte_acc (byte_r),
    .sign_ext (sext_r),
    .data     (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      done_data  <= 1'b0;
      done_inst  <= 1'b0;
      lane_r     <= 2'b00;
      byte_r     <= 1'b0;
      sext_r     <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_sel    <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      load_valid <= 1'b0;
      load_data  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      addr_err   <= 1'b0;
`endif
    end else begin
      load_valid <= 1'b0;
      inst_valid <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      addr_err   <= 1'b0;
`endif

      if (!stall_req) begin
        done_data <= 1'b0;
        done_inst <= 1'b0;
      end else begin
        if (load_valid) done_data <= 1'b1;
        if (inst_valid) done_inst <= 1'b1;
      end

      case (state)
        IDLE: begin
          // bus_ack is deliberately not looked at here
          if (data_go && misaligned) begin
            load_valid <= 1'b1;
            load_data  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            addr_err   <= 1'b1;
`endif
          end else if (data_go) begin
            state     <= DATA;
            bus_req   <= 1'b1;
            bus_we    <= mem_write_flag;
            bus_addr  <= mem_addr & WORD_ADDR_MASK;
            bus_sel   <= is_byte ? (SEL_BYTE << mem_addr[1:0]) : SEL_WORD;
            bus_wdata <= is_byte ? ({24'd0, mem_write_data[7:0]} << {mem_addr[1:0], 3'b000})
                                 : mem_write_data;
            lane_r    <= mem_addr[1:0];
            byte_r    <= is_byte;
            sext_r    <= mem_sign_ext_flag;
          end else if (inst_go) begin
            state    <= INST;
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_addr <= if_addr & WORD_ADDR_MASK;
            bus_sel  <= SEL_WORD;
          end
        end

        DATA: begin
          if (bus_ack) begin
            state      <= IDLE;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            load_valid <= 1'b1;
            // stores only signal completion; load_data keeps its last value
            if (!bus_we) load_data <= ext_data;
          end
        end

        INST: begin
          if (bus_ack) begin
            state      <= IDLE;
            bus_req    <= 1'b0;
            inst_valid <= 1'b1;
            inst_data  <= bus_rdata;
          end
        end

        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
          bus_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Self-checking bench for mem_bus_arbiter: a table of data-access vectors
//   with hand-derived expected bus fields and results, hand-written sequences
//   for arbitration order, reset mid-transaction, ack while idle and (with
//   MEM_ALIGN_CHECK_EN) the misaligned-word error path, then randomized
//   traffic scored against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_flag, mem_write_flag, mem_sign_ext_flag;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_write_data;
  logic        if_req;
  logic [31:0] if_addr;
  logic        bus_req, bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        inst_valid, load_valid, stall_req;
  logic [31:0] inst_data, load_data;
`ifdef MEM_ALIGN_CHECK_EN
  logic        addr_err;
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  mem_bus_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .mem_read_flag     (mem_read_flag),
    .mem_write_flag    (mem_write_flag),
    .mem_sign_ext_flag (mem_sign_ext_flag),
    .mem_sel           (mem_sel),
    .mem_addr          (mem_addr),
    .mem_write_data    (mem_write_data),
    .if_req            (if_req),
    .if_addr           (if_addr),
    .bus_req           (bus_req),
    .bus_we            (bus_we),
    .bus_sel           (bus_sel),
    .bus_addr          (bus_addr),
    .bus_wdata         (bus_wdata),
    .bus_ack           (bus_ack),
    .bus_rdata         (bus_rdata),
    .inst_valid        (inst_valid),
    .inst_data         (inst_data),
    .load_valid        (load_valid),
    .load_data         (load_data),
    .stall_req         (stall_req)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .addr_err          (addr_err)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic logic [3:0] m_sel(input bit byt, input logic [31:0] a);
    int unsigned lane = a % 4;
    if (byt) return 4'(1 << lane);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] a);
    return a - (a % 4);
  endfunction

  function automatic logic [31:0] m_wdata(input bit byt, input logic [31:0] a, input logic [31:0] wd);
    if (byt) return (wd % 256) << (8 * (a % 4));
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input bit byt, input bit sx, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] b;
    if (!byt) return rd;
    b = (rd >> (8 * (a % 4))) % 256;
    if (sx && b >= 128) return b - 32'd256;
    return b;
  endfunction

  typedef struct {
    bit          is_inst;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] result;
    int          waits;
  } txn_t;

  typedef struct {
    bit          wr;
    bit          byt;
    bit          sx;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          waits;
    logic [3:0]  esel;
    logic [31:0] eaddr;
    logic [31:0] ewd;
    logic [31:0] eload;
  } vec_t;

  task automatic clear_inputs();
    mem_read_flag     = 1'b0;
    mem_write_flag    = 1'b0;
    mem_sign_ext_flag = 1'b0;
    mem_sel           = 4'h0;
    mem_addr          = 32'h0;
    mem_write_data    = 32'h0;
    if_req            = 1'b0;
    if_addr           = 32'h0;
  endtask

  // One data access from presentation to the cycle after its valid pulse.
  task automatic run_vec(input int id, input vec_t v);
    int n;
    mem_read_flag     = !v.wr;
    mem_write_flag    = v.wr;
    mem_sign_ext_flag = v.sx;
    mem_sel           = v.byt ? 4'b0001 : 4'b1111;
    mem_addr          = v.addr;
    mem_write_data    = v.wd;
    #1 chk($sformatf("v%0d_stall_pre", id), {31'd0, stall_req}, 32'd1);
    n = 0;
    while (!bus_req && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("v%0d_bus_req", id), {31'd0, bus_req}, 32'd1);
    chk($sformatf("v%0d_bus_we", id), {31'd0, bus_we}, {31'd0, v.wr});
    chk($sformatf("v%0d_bus_sel", id), {28'd0, bus_sel}, {28'd0, v.esel});
    chk($sformatf("v%0d_bus_addr", id), bus_addr, v.eaddr);
    if (v.wr) chk($sformatf("v%0d_bus_wdata", id), bus_wdata, v.ewd);
    repeat (v.waits) begin
      @(negedge clk);
      chk($sformatf("v%0d_hold", id), {30'd0, load_valid, bus_req}, 32'd1);
      chk($sformatf("v%0d_hold_addr", id), bus_addr, v.eaddr);
    end
    bus_ack   = 1'b1;
    bus_rdata = v.rd;
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = $urandom;
    chk($sformatf("v%0d_valid_lv_iv_st_rq", id),
        {28'd0, load_valid, inst_valid, stall_req, bus_req}, 32'h8);
    if (!v.wr) chk($sformatf("v%0d_load_data", id), load_data, v.eload);
    clear_inputs();
    @(negedge clk);
    chk($sformatf("v%0d_pulse_end", id), {30'd0, load_valid, bus_req}, 32'd0);
  endtask

  // Randomized traffic scored against the transaction-level model.
  task automatic run_random(input int iters);
    txn_t exp_q[$];
    txn_t t, cur, fin;
    bit d, f, wr, byt, sx, busy, pend, finished;
    logic [31:0] addr;
    int wcnt, done_n, nexp;
    for (int it = 0; it < iters; it++) begin
      exp_q.delete();
      d   = 1'($urandom_range(0, 1));
      f   = 1'($urandom_range(0, 1));
      if (!d && !f) f = 1'b1;
      wr  = 1'($urandom_range(0, 1));
      byt = 1'($urandom_range(0, 1));
      sx  = 1'($urandom_range(0, 1));
      addr = $urandom;
      if (!byt && ALIGN_CHK) addr[1:0] = 2'b00;
      mem_read_flag     = d && !wr;
      mem_write_flag    = d && wr;
      mem_sign_ext_flag = sx;
      mem_sel           = byt ? 4'b0001 : 4'b1111;
      mem_addr          = addr;
      mem_write_data    = $urandom;
      if_req            = f;
      if_addr           = $urandom;
      // data has priority, so it is expected on the bus first
      if (d) begin
        t.is_inst = 1'b0;
        t.we      = wr;
        t.sel     = m_sel(byt, addr);
        t.addr    = m_addr(addr);
        t.wdata   = m_wdata(byt, addr, mem_write_data);
        t.rdata   = $urandom;
        t.result  = m_load(byt, sx, addr, t.rdata);
        t.waits   = $urandom_range(0, 3);
        exp_q.push_back(t);
      end
      if (f) begin
        t.is_inst = 1'b1;
        t.we      = 1'b0;
        t.sel     = 4'hF;
        t.addr    = m_addr(if_addr);
        t.wdata   = 32'h0;
        t.rdata   = $urandom;
        t.result  = t.rdata;
        t.waits   = $urandom_range(0, 3);
        exp_q.push_back(t);
      end
      nexp = exp_q.size();
      busy = 1'b0;
      pend = 1'b0;
      finished = 1'b0;
      wcnt = 0;
      done_n = 0;
      for (int c = 0; c < 60 && !finished; c++) begin
        @(negedge clk);
        bus_ack = 1'b0;
        if (pend) begin
          chk("rnd_valid_kind", {30'd0, inst_valid, load_valid},
              fin.is_inst ? 32'd2 : 32'd1);
          if (fin.is_inst) chk("rnd_inst_data", inst_data, fin.result);
          else if (!fin.we) chk("rnd_load_data", load_data, fin.result);
          pend = 1'b0;
          done_n++;
        end else begin
          chk("rnd_no_valid", {30'd0, inst_valid, load_valid}, 32'd0);
        end
        if (!stall_req) begin
          finished = 1'b1;
        end else if (bus_req) begin
          if (!busy) begin
            chk("rnd_req_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
              cur  = exp_q.pop_front();
              busy = 1'b1;
              wcnt = cur.waits;
              chk("rnd_bus_we", {31'd0, bus_we}, {31'd0, cur.we});
              chk("rnd_bus_sel", {28'd0, bus_sel}, {28'd0, cur.sel});
              chk("rnd_bus_addr", bus_addr, cur.addr);
              if (cur.we) chk("rnd_bus_wdata", bus_wdata, cur.wdata);
            end
          end
          if (busy) begin
            if (wcnt == 0) begin
              bus_ack   = 1'b1;
              bus_rdata = cur.rdata;
              fin       = cur;
              pend      = 1'b1;
              busy      = 1'b0;
            end else begin
              wcnt--;
              bus_rdata = $urandom;
            end
          end
        end
      end
      chk("rnd_finished", {31'd0, finished}, 32'd1);
      chk("rnd_all_done", done_n, nexp);
      clear_inputs();
      @(negedge clk);
      chk("rnd_idle_after", {29'd0, bus_req, inst_valid, load_valid}, 32'd0);
    end
  endtask

  vec_t vecs[$];

  initial begin
    // {wr, byt, sx, addr, wdata, rdata, waits, exp sel, exp addr, exp wdata, exp load}
    vecs.push_back('{0, 0, 0, 32'h100, 32'h0,        32'hDEADBEEF, 2, 4'hF, 32'h100, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{0, 1, 1, 32'h103, 32'h0,        32'h80FFFFFF, 0, 4'h8, 32'h100, 32'h0,        32'hFFFFFF80});
    vecs.push_back('{0, 1, 0, 32'h103, 32'h0,        32'h80FFFFFF, 0, 4'h8, 32'h100, 32'h0,        32'h00000080});
    vecs.push_back('{1, 1, 0, 32'h201, 32'h12345678, 32'h0,        1, 4'h2, 32'h200, 32'h00007800, 32'h0});
    vecs.push_back('{0, 1, 1, 32'h200, 32'h0,        32'h12345681, 0, 4'h1, 32'h200, 32'h0,        32'hFFFFFF81});
    vecs.push_back('{0, 1, 0, 32'h302, 32'h0,        32'h00AB0000, 3, 4'h4, 32'h300, 32'h0,        32'h000000AB});
    vecs.push_back('{1, 0, 0, 32'h400, 32'hCAFEF00D, 32'h0,        1, 4'hF, 32'h400, 32'hCAFEF00D, 32'h0});
    vecs.push_back('{1, 1, 0, 32'h503, 32'h000000A5, 32'h0,        0, 4'h8, 32'h500, 32'hA5000000, 32'h0});
    vecs.push_back('{0, 1, 1, 32'h101, 32'h0,        32'h00007F00, 0, 4'h2, 32'h100, 32'h0,        32'h0000007F});
`ifndef MEM_ALIGN_CHECK_EN
    vecs.push_back('{0, 0, 0, 32'h106, 32'h0,        32'h11223344, 0, 4'hF, 32'h104, 32'h0,        32'h11223344});
`endif

    // reset with requests present: everything must read zero
    rst       = 1'b1;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    clear_inputs();
    mem_read_flag = 1'b1;
    mem_sel       = 4'hF;
    if_req        = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ctrl_rq_we_iv_lv_st", {27'd0, bus_req, bus_we, inst_valid, load_valid, stall_req}, 32'd0);
    chk("rst_bus_sel", {28'd0, bus_sel}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);

    // ack while idle must be ignored
    bus_ack   = 1'b1;
    bus_rdata = 32'h55AA55AA;
    @(negedge clk);
    bus_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_ignored", {29'd0, bus_req, inst_valid, load_valid}, 32'd0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // load and fetch presented together: data first, fetch after one idle cycle
    mem_read_flag = 1'b1;
    mem_sel       = 4'hF;
    mem_addr      = 32'h100;
    if_req        = 1'b1;
    if_addr       = 32'h1006;
    @(negedge clk);
    chk("p35_data_req", {31'd0, bus_req}, 32'd1);
    chk("p35_data_addr", bus_addr, 32'h100);
    chk("p35_data_we", {31'd0, bus_we}, 32'd0);
    bus_ack   = 1'b1;
    bus_rdata = 32'h0BADF00D;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("p35_load_rq_iv_lv_st", {28'd0, bus_req, inst_valid, load_valid, stall_req}, 32'h3);
    chk("p35_load_data", load_data, 32'h0BADF00D);
    @(negedge clk);
    chk("p35_fetch_req", {31'd0, bus_req}, 32'd1);
    chk("p35_fetch_addr", bus_addr, 32'h1004);
    chk("p35_fetch_sel_we", {27'd0, bus_sel, bus_we}, 32'h1E);
    chk("p35_fetch_lv_st", {30'd0, load_valid, stall_req}, 32'd1);
    bus_ack   = 1'b1;
    bus_rdata = 32'h13579BDF;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("p35_inst_rq_iv_lv_st", {28'd0, bus_req, inst_valid, load_valid, stall_req}, 32'h4);
    chk("p35_inst_data", inst_data, 32'h13579BDF);
    clear_inputs();
    @(negedge clk);
    chk("p35_quiet", {29'd0, bus_req, inst_valid, load_valid}, 32'd0);

    // reset while waiting for ack; a late ack must produce nothing
    mem_read_flag = 1'b1;
    mem_sel       = 4'hF;
    mem_addr      = 32'h100;
    @(negedge clk);
    chk("p36_req_before", {31'd0, bus_req}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("p36_async_rq_st", {30'd0, bus_req, stall_req}, 32'd0);
    chk("p36_async_sel", {28'd0, bus_sel}, 32'd0);
    clear_inputs();
    @(negedge clk);
    rst       = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("p36_late_ack", {29'd0, bus_req, inst_valid, load_valid}, 32'd0);
    @(negedge clk);
    chk("p36_late_ack2", {29'd0, bus_req, inst_valid, load_valid}, 32'd0);
    run_vec(100, vecs[0]);

`ifdef MEM_ALIGN_CHECK_EN
    // misaligned word store: no bus cycle, one-cycle error pulse
    mem_write_flag = 1'b1;
    mem_sel        = 4'hF;
    mem_addr       = 32'h102;
    mem_write_data = 32'hA5A5A5A5;
    #1 chk("p37_stall_pre", {31'd0, stall_req}, 32'd1);
    @(negedge clk);
    chk("p37_rq_ae_lv_st", {28'd0, bus_req, addr_err, load_valid, stall_req}, 32'h6);
    chk("p37_load_data", load_data, 32'd0);
    clear_inputs();
    @(negedge clk);
    chk("p37_pulse_end", {29'd0, bus_req, addr_err, load_valid}, 32'd0);
`endif

    run_random(150);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have no parameters; data and address widths are 32 bits, select width is 4 bits, taken from the shared bus definitions.
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports mem_read_flag and mem_write_flag, inputs, 1 bit each: a load or store is requested by the ID/EX path.
REQ-005 SHALL have ports mem_sign_ext_flag (input, 1), mem_sel (input, 4), mem_addr (input, 32), mem_write_data (input, 32): the decoded memory-access attributes.
REQ-006 SHALL have ports if_req (input, 1) and if_addr (input, 32): an instruction-fetch request.
REQ-007 SHALL have ports bus_req, bus_we (outputs, 1 each), bus_sel (output, 4), bus_addr and bus_wdata (outputs, 32): the shared memory bus request, all registered.
REQ-008 SHALL have ports bus_ack (input, 1) and bus_rdata (input, 32): bus completion and read data.
REQ-009 SHALL have ports inst_valid (output, 1) and inst_data (output, 32): fetch result.
REQ-010 SHALL have ports load_valid (output, 1) and load_data (output, 32): load result; for stores, load_valid signals completion.
REQ-011 SHALL have port stall_req, output, 1 bit: freezes the pipeline.
REQ-012 SHALL have port addr_err, output, 1 bit, present only when MEM_ALIGN_CHECK_EN is defined.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, DATA and INST.
- IDLE -> DATA when read or write is requested.
- Else IDLE -> INST when if_req is high.
- DATA/INST -> IDLE in the cycle bus_ack is sampled high.
REQ-014 SHALL give data access strict priority over fetch when both are requested in the same IDLE cycle.
REQ-015 SHALL register the bus_req/bus_we/bus_sel/bus_addr/bus_wdata outputs on the IDLE exit edge and hold them stable until bus_ack.
REQ-016 SHALL drive bus_addr as {mem_addr[31:2],2'b00} for data and {if_addr[31:2],2'b00} for fetch.
REQ-017 SHALL form bus_sel for a byte access (mem_sel = 0001) as 0001 shifted left by mem_addr[1:0]; for a word access bus_sel = 1111; for fetch bus_sel = 1111 and bus_we = 0.
REQ-018 SHALL replicate byte stores into the correct lane: bus_wdata = mem_write_data[7:0] shifted left by 8*mem_addr[1:0]; word stores pass through unchanged.
REQ-019 SHALL, for loads, register load_data from bus_rdata on ack.
- Byte loads: select lane mem_addr[1:0], then sign-extend if mem_sign_ext_flag is set, otherwise zero-extend.
- Word loads: pass through.
REQ-020 SHALL pulse load_valid (or inst_valid) high for exactly one cycle, the cycle after bus_ack; inst_data is registered from bus_rdata.
REQ-021 SHALL hold stall_req high, combinationally, whenever a data request or if_req is present and its valid pulse is not high in that cycle.
REQ-022 SHALL ignore bus_ack while in IDLE.
REQ-023 SHALL have a minimum latency of 3 cycles from request presentation to valid pulse with zero-wait ack (issue, ack, valid).
REQ-024 SHALL insert one IDLE cycle between consecutive transactions.
REQ-025 SHALL rely on inputs being held stable while stall_req is high; behaviour on input change mid-transaction is undefined.

Reset
REQ-026 SHALL force, on rst high and regardless of clk, FSM = IDLE and all outputs = 0.
REQ-027 SHALL abandon an outstanding bus transaction when reset occurs mid-operation; a late bus_ack after reset is ignored.

Configuration
REQ-028 SHALL, when MEM_ALIGN_CHECK_EN is defined:
- treat a word access with mem_addr[1:0] != 0 as issuing no bus transaction;
- pulse addr_err and load_valid for one cycle, the cycle after presentation, with load_data = 0;
- leave byte accesses unaffected.
REQ-029 SHALL, when MEM_ALIGN_CHECK_EN is undefined, have no addr_err port and issue misaligned word accesses with the address bits [1:0] cleared.

Structure
REQ-030 SHALL place the FSM state encoding and the select constants (SEL_BYTE=0001, SEL_WORD=1111) in the shared bus/opcode definitions.
REQ-031 SHALL factor lane extraction and extension into one combinational sub-module, mem_lane_extract.

Verification
REQ-032 SHALL cover: lw at 0x100, rdata 0xDEADBEEF, ack after 2 wait cycles -> bus_sel 1111, load_data 0xDEADBEEF, stall_req low the cycle load_valid pulses.
REQ-033 SHALL cover: lb at 0x103 with sign-ext, rdata 0x80FF_FFFF -> bus_sel 1000, load_data 0xFFFFFF80; the same access as lbu -> 0x00000080.
REQ-034 SHALL cover: sb at 0x201, data 0x12345678 -> bus_we 1, bus_sel 0010, bus_wdata 0x00007800, bus_addr 0x200.
REQ-035 SHALL cover: lw and if_req presented in the same cycle -> data transaction first; fetch bus_req follows after one IDLE cycle; inst_valid pulses after its ack.
REQ-036 SHALL cover: rst asserted while in DATA awaiting ack -> bus_req 0 immediately, FSM IDLE; a subsequent bus_ack produces no valid pulse.
REQ-037 SHALL cover, with MEM_ALIGN_CHECK_EN defined: sw at 0x102 -> bus_req stays 0, addr_err and load_valid pulse for 1 cycle.
